// File: rtl/serial_pattern_sched.sv
`default_nettype none
// ============================================================================
// serial_pattern_sched : round-robin scheduler feeding two requesters' words
// MSB-first through one shared serial Moore pattern detector, with per-
// requester saturating match counters. Option macro: SPS_NONOVERLAP_EN.
// Revision: 1.0
// ============================================================================
module serial_pattern_sched #(
    parameter int WORD_W = 8,
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pat_load,
    input  logic [PAT_W-1:0]  pattern_in,
    input  logic              req0,
    input  logic [WORD_W-1:0] data0,
    input  logic              req1,
    input  logic [WORD_W-1:0] data1,
    output logic              ack0,
    output logic              ack1,
    output logic              busy,
    output logic              bit_valid,
    output logic              bit_out,
    output logic              z,
    output logic              done,
    output logic [CNT_W-1:0]  match_cnt0,
    output logic [CNT_W-1:0]  match_cnt1
);

    localparam int IDX_W  = $clog2(WORD_W);
    localparam int FILL_W = $clog2(PAT_W + 1);

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORD_W - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [PAT_W-1:0]  PAT_RST   = PAT_W'(4'b1101);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [PAT_W-1:0]    pattern;
    logic [PAT_W-1:0]    pat_act;
    logic                last_grant;
    logic [WORD_W-1:0]   shreg;
    logic [IDX_W-1:0]    bit_idx;
    logic [PAT_W-1:0]    history;
    logic [FILL_W-1:0]   fill;
    logic                z_q;
    logic [CNT_W-1:0]    cnt0;
    logic [CNT_W-1:0]    cnt1;

    logic                pick;
    logic                cur_bit;
    logic [PAT_W-1:0]    hist_nxt;
    logic [FILL_W-1:0]   fill_nxt;
    logic                hit;

    // With both requesting, the one not served last wins; otherwise the lone requester.
    assign pick     = (req0 && req1) ? ~last_grant : req1;
    assign cur_bit  = shreg[WORD_W-1];
    assign hist_nxt = {history[PAT_W-2:0], cur_bit};
    assign fill_nxt = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);
    assign hit      = (fill_nxt == FILL_FULL) && (hist_nxt == pat_act);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ack0      = 1'b0;
        ack1      = 1'b0;
        busy      = 1'b0;
        bit_valid = 1'b0;
        bit_out   = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                busy      = 1'b1;
                ack0      = ~last_grant;
                ack1      = last_grant;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                busy      = 1'b1;
                bit_valid = 1'b1;
                bit_out   = cur_bit;
                if (bit_idx == LAST_IDX) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern    <= PAT_RST;
            pat_act    <= PAT_RST;
            last_grant <= 1'b1;
            shreg      <= '0;
            bit_idx    <= '0;
            history    <= '0;
            fill       <= '0;
            z_q        <= 1'b0;
            cnt0       <= '0;
            cnt1       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pat_load) begin
                        pattern <= pattern_in;
                    end
                    if (req0 || req1) begin
                        last_grant <= pick;
                    end
                end
                GRANT: begin
                    // Snapshot the pattern so later loads cannot disturb this word.
                    shreg   <= last_grant ? data1 : data0;
                    pat_act <= pattern;
                    bit_idx <= '0;
                    history <= '0;
                    fill    <= '0;
                    z_q     <= 1'b0;
                end
                SHIFT: begin
                    shreg   <= {shreg[WORD_W-2:0], 1'b0};
                    bit_idx <= bit_idx + IDX_W'(1);
                    history <= hist_nxt;
                    fill    <= fill_nxt;
                    z_q     <= hit;
                    if (hit) begin
                        if (!last_grant) begin
                            if (cnt0 != {CNT_W{1'b1}}) begin
                                cnt0 <= cnt0 + CNT_W'(1);
                            end
                        end else begin
                            if (cnt1 != {CNT_W{1'b1}}) begin
                                cnt1 <= cnt1 + CNT_W'(1);
                            end
                        end
`ifdef SPS_NONOVERLAP_EN
                        history <= '0;
                        fill    <= '0;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign z          = z_q;
    assign match_cnt0 = cnt0;
    assign match_cnt1 = cnt1;

endmodule
`default_nettype wire

// File: tb/tb_serial_pattern_sched.sv
`default_nettype none
// Bench for serial_pattern_sched: word-level timeline model checked every cycle,
// plus directed scenarios with hand-computed literals.
module tb_serial_pattern_sched;

    localparam int WORD_W = 8;
    localparam int PAT_W  = 4;
    localparam int CNT_W  = 8;
    localparam int CMAX   = (1 << CNT_W) - 1;
    localparam logic [WORD_W-1:0] PMASK = WORD_W'((1 << PAT_W) - 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              pat_load;
    logic [PAT_W-1:0]  pattern_in;
    logic              req0;
    logic [WORD_W-1:0] data0;
    logic              req1;
    logic [WORD_W-1:0] data1;
    logic              ack0;
    logic              ack1;
    logic              busy;
    logic              bit_valid;
    logic              bit_out;
    logic              z;
    logic              done;
    logic [CNT_W-1:0]  match_cnt0;
    logic [CNT_W-1:0]  match_cnt1;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    serial_pattern_sched #(.WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .pat_load   (pat_load),
        .pattern_in (pattern_in),
        .req0       (req0),
        .data0      (data0),
        .req1       (req1),
        .data1      (data1),
        .ack0       (ack0),
        .ack1       (ack1),
        .busy       (busy),
        .bit_valid  (bit_valid),
        .bit_out    (bit_out),
        .z          (z),
        .done       (done),
        .match_cnt0 (match_cnt0),
        .match_cnt1 (match_cnt1)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
        end
    endtask

    // ---------------- word-level model ----------------
    // A word occupies phases 0 (grant), 1..WORD_W (bits), WORD_W+1 (done).
    bit                m_busy;
    int                m_ph, m_g, m_last, m_c0, m_c1;
    bit                m_z;
    logic [WORD_W-1:0] m_word;
    logic [PAT_W-1:0]  m_pat;
    bit                m_hit [1:WORD_W];

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    function automatic int nhits(input int upto);
        int n = 0;
        for (int k = 1; k <= upto; k++) n += int'(m_hit[k]);
        return n;
    endfunction

    task automatic m_reset();
        m_busy = 0; m_ph = 0; m_g = 0; m_last = 1;
        m_c0 = 0; m_c1 = 0; m_z = 0; m_pat = PAT_W'(4'b1101); m_word = '0;
    endtask

    // Bit k (1-based, MSB first) completes a match when the PAT_W bits ending at k equal the pattern.
    task automatic find_hits();
        int last;
        logic [WORD_W-1:0] sl;
        last = 0;
        for (int k = 1; k <= WORD_W; k++) begin
            m_hit[k] = 0;
            if (k >= PAT_W) begin
                sl = (m_word >> (WORD_W - k)) & PMASK;
                if (sl[PAT_W-1:0] == m_pat && (k - last) >= PAT_W) begin
                    m_hit[k] = 1;
`ifdef SPS_NONOVERLAP_EN
                    last = k;
`endif
                end
            end
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_reset();
            end else if (!m_busy) begin
                if (pat_load) m_pat = pattern_in;
                if (req0 || req1) begin
                    m_g    = (req0 && req1) ? (1 - m_last) : (req0 ? 0 : 1);
                    m_last = m_g;
                    m_busy = 1;
                    m_ph   = 0;
                end
            end else if (m_ph == 0) begin
                m_word = (m_g == 1) ? data1 : data0;
                find_hits();
                m_ph = 1;
            end else if (m_ph == WORD_W + 1) begin
                m_busy = 0;
                m_z    = m_hit[WORD_W];
                if (m_g == 0) m_c0 = sat(m_c0 + nhits(WORD_W));
                else          m_c1 = sat(m_c1 + nhits(WORD_W));
            end else begin
                m_ph++;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int e_c0, e_c1, up;
    bit e_z, e_bit, e_bv, e_busy, e_ack0, e_ack1, e_done;

    initial begin
        forever begin
            @(negedge clk);
            e_c0 = m_c0; e_c1 = m_c1; e_z = m_z; e_bit = 0; e_bv = 0;
            e_busy = m_busy; e_ack0 = 0; e_ack1 = 0; e_done = 0;
            if (m_busy) begin
                if (m_ph == 0) begin
                    e_ack0 = (m_g == 0);
                    e_ack1 = (m_g == 1);
                end else begin
                    up  = m_ph - 1;
                    e_z = (up >= 1) ? m_hit[up] : 1'b0;
                    if (m_g == 0) e_c0 = sat(m_c0 + nhits(up));
                    else          e_c1 = sat(m_c1 + nhits(up));
                    if (m_ph <= WORD_W) begin
                        e_bv  = 1;
                        e_bit = m_word[WORD_W - m_ph];
                    end else begin
                        e_done = 1;
                    end
                end
            end
            chk("ack0",      int'(ack0),      int'(e_ack0));
            chk("ack1",      int'(ack1),      int'(e_ack1));
            chk("busy",      int'(busy),      int'(e_busy));
            chk("bit_valid", int'(bit_valid), int'(e_bv));
            chk("bit_out",   int'(bit_out),   int'(e_bit));
            chk("z",         int'(z),         int'(e_z));
            chk("done",      int'(done),      int'(e_done));
            chk("cnt0",      int'(match_cnt0), e_c0);
            chk("cnt1",      int'(match_cnt1), e_c1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    // which: 0=ack0, 1=ack1, 2=done
    task automatic wait_for(input int which, input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            step();
            seen = (which == 0) ? ack0 : (which == 1) ? ack1 : done;
        end
        chk(name, int'(seen), 1);
    endtask

    task automatic do_word(input int r, input logic [WORD_W-1:0] d);
        if (r == 0) begin req0 = 1; data0 = d; end
        else        begin req1 = 1; data1 = d; end
        wait_for(r, "word_ack");
        req0 = 0; req1 = 0;
        wait_for(2, "word_done");
    endtask

    task automatic do_reset();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    logic [WORD_W-1:0] bits, zs;
    int order [0:4];
    int dt [0:4];
    int na, nd;
    bit zany;

    initial begin
        pat_load = 0; pattern_in = '0; req0 = 0; req1 = 0; data0 = '0; data1 = '0;
        step(); step();
        rst = 0;
        step();
        chk("rst_busy", int'(busy), 0);
        chk("rst_cnt0", int'(match_cnt0), 0);
        chk("rst_z",    int'(z), 0);

        // single word, default pattern 1101
        req0 = 1; data0 = 8'b11011011;
        step();
        chk("t1_ack_latency", int'(ack0), 1);
        req0 = 0;
        bits = '0; zs = '0;
        for (int i = 0; i < WORD_W; i++) begin
            step();
            bits = {bits[WORD_W-2:0], bit_out};
            zs   = {zs[WORD_W-2:0], z};
        end
        chk("t1_bits", int'(bits), 8'b11011011);
`ifdef SPS_NONOVERLAP_EN
        chk("t1_zseq", int'(zs), 8'b00001000);
`else
        chk("t1_zseq", int'(zs), 8'b00001001);
`endif
        step();
        chk("t1_done", int'(done), 1);
`ifdef SPS_NONOVERLAP_EN
        chk("t1_cnt0", int'(match_cnt0), 1);
`else
        chk("t1_cnt0", int'(match_cnt0), 2);
`endif

        // both requesters held: round-robin order and spacing
        do_reset();
        data0 = '0; data1 = '0; req0 = 1; req1 = 1;
        na = 0; nd = 0; zany = 0;
        for (int i = 0; i < 100 && nd < 5; i++) begin
            step();
            if (ack0 || ack1) begin
                if (na < 5) order[na] = int'(ack1);
                na++;
                if (na == 4) req1 = 0;
                if (na == 5) req0 = 0;
            end
            if (done) begin
                if (nd < 5) dt[nd] = cyc;
                nd++;
            end
            zany = zany | z;
        end
        chk("t2_ndone", nd, 5);
        chk("t2_ord0", order[0], 0);
        chk("t2_ord1", order[1], 1);
        chk("t2_ord2", order[2], 0);
        chk("t2_ord3", order[3], 1);
        for (int i = 0; i < 4; i++) chk("t2_spacing", dt[i+1] - dt[i], 11);
        chk("t2_cnt0", int'(match_cnt0), 0);
        chk("t2_cnt1", int'(match_cnt1), 0);
        chk("t2_zany", int'(zany), 0);

        // pattern 0000 loaded in IDLE, ignored load during SHIFT
        step();
        pat_load = 1; pattern_in = 4'b0000;
        step();
        pat_load = 0;
        req1 = 1; data1 = 8'b00000000;
        wait_for(1, "t3_ack1");
        req1 = 0;
        step(); step();
        pat_load = 1; pattern_in = 4'b1111;
        step();
        pat_load = 0;
        wait_for(2, "t3_done");
`ifdef SPS_NONOVERLAP_EN
        chk("t3_cnt1", int'(match_cnt1), 2);
        do_word(1, 8'b00000000);
        chk("t3_cnt1_again", int'(match_cnt1), 4);
`else
        chk("t3_cnt1", int'(match_cnt1), 5);
        do_word(1, 8'b00000000);
        chk("t3_cnt1_again", int'(match_cnt1), 10);
`endif

        // reset in SHIFT cycle 3
        req0 = 1; data0 = 8'b11011011;
        wait_for(0, "t4_ack0");
        req0 = 0;
        step(); step(); step();
        chk("t4_pre_valid", int'(bit_valid), 1);
        rst = 1;
        #1;
        chk("t4_busy",  int'(busy), 0);
        chk("t4_valid", int'(bit_valid), 0);
        chk("t4_bit",   int'(bit_out), 0);
        chk("t4_z",     int'(z), 0);
        chk("t4_cnt0",  int'(match_cnt0), 0);
        chk("t4_cnt1",  int'(match_cnt1), 0);
        step();
        rst = 0;
        nd = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (done) nd++;
        end
        chk("t4_nodone", nd, 0);
        do_word(0, 8'b11011011);
`ifdef SPS_NONOVERLAP_EN
        chk("t4_pattern_back", int'(match_cnt0), 1);
`else
        chk("t4_pattern_back", int'(match_cnt0), 2);
`endif

        // match on the final bit: z through DONE and IDLE, cleared by next grant
        do_word(0, 8'b00001101);
        chk("t6_z_done", int'(z), 1);
`ifdef SPS_NONOVERLAP_EN
        chk("t6_cnt0", int'(match_cnt0), 2);
`else
        chk("t6_cnt0", int'(match_cnt0), 3);
`endif
        step(); step();
        chk("t6_z_idle", int'(z), 1);
        req0 = 1; data0 = 8'b11010000;
        wait_for(0, "t6_ack0");
        req0 = 0;
        step();
        chk("t6_z_cleared", int'(z), 0);
        wait_for(2, "t6_done");

        // saturation: 256 words with one match each
        for (int w = 0; w < 255; w++) do_word(0, 8'b11010000);
        chk("t5_sat", int'(match_cnt0), 255);
        do_word(0, 8'b11010000);
        chk("t5_sat_hold", int'(match_cnt0), 255);
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
